// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: pops WORD_WIDTH-bit words from a FIFO read port that has
// one cycle of registered read latency, and serialises each word into
// BYTE_WIDTH-bit beats on a valid/ready stream.
// Optional build macro: UNPACKER_LSB_FIRST_EN (least-significant beat first).
// Without it, the most-significant beat is sent first.
module fifo_byte_unpacker #(
    parameter int WORD_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic [BYTE_WIDTH-1:0] byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      word_cnt
);

    localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                             state, state_nxt;
    logic [IDX_W-1:0]                   idx;
    logic [IDX_W-1:0]                   byte_sel;
    logic [NBYTES-1:0][BYTE_WIDTH-1:0]  word_reg;

    wire handshake = (state == SEND) && byte_ready;

    // State register, captured word, beat index and completed-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            word_reg <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: begin
                    word_reg <= fifo_dout;
                    idx      <= '0;
                end
                SEND: begin
                    if (handshake) begin
                        if (idx == LAST_IDX) begin
                            idx      <= '0;
                            word_cnt <= word_cnt + CNT_W'(1);
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and pop request; a pop is only issued from IDLE, so
    // at most one word is ever in flight. Popping is held off during reset
    // so a word is not lost while the datapath is being cleared.
    always_comb begin
        state_nxt = state;
        fifo_ren  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !rst) begin
                    fifo_ren  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = SEND;
            SEND: begin
                if (handshake && (idx == LAST_IDX))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat selection: slot NBYTES-1 of word_reg is the most-significant slice
    always_comb begin
`ifdef UNPACKER_LSB_FIRST_EN
        byte_sel = idx;
`else
        byte_sel = LAST_IDX - idx;
`endif
    end

    // Outputs decode registered state only; byte_ready never reaches them
    assign byte_out   = word_reg[byte_sel];
    assign byte_valid = (state == SEND);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// tb_fifo_byte_unpacker: directed, table-driven bench with a small FIFO model
// that has one cycle of registered read latency. word_cnt is built 2 bits wide
// so that counter wrap is reachable.
module tb_fifo_byte_unpacker;

    logic        clk;
    logic        rst;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic [1:0]  word_cnt;

    int total = 0;
    int bad   = 0;

    fifo_byte_unpacker #(.WORD_WIDTH(16), .BYTE_WIDTH(8), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_ren(fifo_ren), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .busy(busy), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data appears on fifo_dout the cycle after a pop
    logic [15:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    int ren_total = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_ren) begin
            fifo_dout <= mem[rp % 64];
            rp        <= rp + 1;
            ren_total <= ren_total + 1;
        end
    end

    task automatic push(input logic [15:0] w);
        mem[wp % 64] = w;
        wp = wp + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] beat(input logic [15:0] w, input int i);
`ifdef UNPACKER_LSB_FIRST_EN
        return (i == 0) ? w[7:0] : w[15:8];
`else
        return (i == 0) ? w[15:8] : w[7:0];
`endif
    endfunction

    typedef struct {
        bit          push;
        logic [15:0] word;
        bit          ready;
        bit          ren;
        bit          valid;
        logic [7:0]  bt;
        bit          busy;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit p, logic [15:0] w, bit r, bit ren, bit v,
                                logic [7:0] b, bit bz, logic [1:0] c);
        vec_t t;
        t.push = p; t.word = w; t.ready = r; t.ren = ren;
        t.valid = v; t.bt = b; t.busy = bz; t.cnt = c;
        return t;
    endfunction

    initial begin
        logic [7:0] seq [$];
        int         ren_cyc [$];
        logic [1:0] cnt_seen [$];
        logic [1:0] prev;
        bit         seen;
        int         ren0;
        logic [7:0] exp6 [6];
        logic [1:0] expw [5];

        rst = 1'b1;
        byte_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_outs", {fifo_ren, byte_valid, busy, byte_out, word_cnt},
            {1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        rst = 1'b0;

        // Single word at full rate, then backpressured word
        tbl.push_back(mk(1, 16'hA1B2, 1, 1, 0, 8'h00, 0, 2'd0));
        tbl.push_back(mk(0, 16'h0,    1, 0, 0, 8'h00, 1, 2'd0));
        tbl.push_back(mk(0, 16'h0,    1, 0, 1, beat(16'hA1B2, 0), 1, 2'd0));
        tbl.push_back(mk(0, 16'h0,    1, 0, 1, beat(16'hA1B2, 1), 1, 2'd0));
        tbl.push_back(mk(0, 16'h0,    1, 0, 0, 8'h00, 0, 2'd1));
        tbl.push_back(mk(0, 16'h0,    1, 0, 0, 8'h00, 0, 2'd1));
        tbl.push_back(mk(1, 16'h1234, 0, 1, 0, 8'h00, 0, 2'd1));
        tbl.push_back(mk(0, 16'h0,    0, 0, 0, 8'h00, 1, 2'd1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 16'h0, 0, 0, 1, beat(16'h1234, 0), 1, 2'd1));
        tbl.push_back(mk(0, 16'h0,    1, 0, 1, beat(16'h1234, 0), 1, 2'd1));
        tbl.push_back(mk(0, 16'h0,    1, 0, 1, beat(16'h1234, 1), 1, 2'd1));
        tbl.push_back(mk(0, 16'h0,    1, 0, 0, 8'h00, 0, 2'd2));
        tbl.push_back(mk(0, 16'h0,    1, 0, 0, 8'h00, 0, 2'd2));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].push) push(tbl[i].word);
            byte_ready = tbl[i].ready;
            #1;
            chk($sformatf("row%0d", i),
                {fifo_ren, byte_valid, busy, (byte_valid ? byte_out : 8'h00), word_cnt},
                {tbl[i].ren, tbl[i].valid, tbl[i].busy, tbl[i].bt, tbl[i].cnt});
            step();
        end
        chk("ren_count_tbl", ren_total, 2);

        // Empty FIFO: nothing happens for 20 cycles
        do_reset();
        ren0 = ren_total;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fifo_ren || byte_valid || busy) seen = 1;
        end
        chk("empty_idle", seen, 0);
        chk("empty_cnt", word_cnt, 2'd0);
        chk("empty_no_pop", ren_total - ren0, 0);

        // Back-to-back words
        rst = 1'b1;
        step();
        step();
        push(16'h0102); push(16'h0304); push(16'h0506);
        byte_ready = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (fifo_ren) ren_cyc.push_back(c);
            if (byte_valid) seq.push_back(byte_out);
            @(posedge clk);
            #1;
        end
        exp6[0] = beat(16'h0102, 0); exp6[1] = beat(16'h0102, 1);
        exp6[2] = beat(16'h0304, 0); exp6[3] = beat(16'h0304, 1);
        exp6[4] = beat(16'h0506, 0); exp6[5] = beat(16'h0506, 1);
        chk("b2b_nbytes", seq.size(), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++)
            chk($sformatf("b2b_byte%0d", i), seq[i], exp6[i]);
        chk("b2b_npop", ren_cyc.size(), 3);
        if (ren_cyc.size() == 3) begin
            chk("b2b_gap1", ren_cyc[1] - ren_cyc[0], 4);
            chk("b2b_gap2", ren_cyc[2] - ren_cyc[1], 4);
        end
        chk("b2b_cnt", word_cnt, 2'd3);

        // Reset while the second beat of a word is pending
        do_reset();
        byte_ready = 1'b1;
        push(16'hAABB);
        for (int i = 0; i < 10 && !byte_valid; i++) step();
        chk("mid_valid", byte_valid, 1'b1);
        chk("mid_beat0", byte_out, beat(16'hAABB, 0));
        step();
        chk("mid_beat1_shown", {byte_valid, byte_out}, {1'b1, beat(16'hAABB, 1)});
        rst = 1'b1;
        step();
        chk("mid_rst", {byte_valid, busy, word_cnt}, {1'b0, 1'b0, 2'd0});
        rst = 1'b0;
        push(16'hCCDD);
        for (int i = 0; i < 10 && !byte_valid; i++) step();
        chk("after_rst_beat0", {byte_valid, byte_out}, {1'b1, beat(16'hCCDD, 0)});
        step();
        chk("after_rst_beat1", {byte_valid, byte_out}, {1'b1, beat(16'hCCDD, 1)});
        step();
        chk("after_rst_cnt", {busy, word_cnt}, {1'b0, 2'd1});

        // Counter wrap with a 2-bit counter
        do_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(16'h1000 + 16'(i));
        prev = word_cnt;
        for (int c = 0; c < 40 && cnt_seen.size() < 5; c++) begin
            step();
            if (word_cnt != prev) begin
                cnt_seen.push_back(word_cnt);
                prev = word_cnt;
            end
        end
        expw[0] = 2'd1; expw[1] = 2'd2; expw[2] = 2'd3; expw[3] = 2'd0; expw[4] = 2'd1;
        chk("wrap_n", cnt_seen.size(), 5);
        for (int i = 0; i < 5 && i < cnt_seen.size(); i++)
            chk($sformatf("wrap%0d", i), cnt_seen[i], expw[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
